// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port memory with
// one-cycle read latency. Each access runs IDLE -> ISSUE -> RESP (3 cycles).
module mem_arbiter #(
  parameter int ADDR_W = 24,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  input  logic              we0,
  input  logic              we1,
  output logic              done0,
  output logic              done1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic                r_prio;
  logic                r_id;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;

  logic                w_grant;
  logic                w_grant_id;
  logic [ADDR_W-1:0]   w_sel_addr;
  logic [DATA_W-1:0]   w_sel_wdata;
  logic                w_sel_we;

  // Next-state, arbitration and output decode. Outputs are forced quiet
  // while rst is high so an in-flight access is squashed immediately.
  always_comb begin
    w_state_next = r_state;
    w_grant      = 1'b0;
    w_grant_id   = 1'b0;
    done0        = 1'b0;
    done1        = 1'b0;
    rdata0       = '0;
    rdata1       = '0;
    mem_addr     = '0;
    mem_wdata    = '0;
    mem_we       = 1'b0;
    busy         = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (req0 || req1) begin
          w_grant      = 1'b1;
          // A lone requester wins outright; a tie goes to the prio side.
          w_grant_id   = (req0 && req1) ? r_prio : req1;
          w_state_next = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        w_state_next = ST_RESP;
        if (!rst) begin
          busy      = 1'b1;
          mem_addr  = r_addr;
          mem_wdata = r_wdata;
          mem_we    = r_we;
        end
      end
      ST_RESP: begin
        w_state_next = ST_IDLE;
        if (!rst) begin
          busy = 1'b1;
          if (r_id) begin
            done1  = 1'b1;
            rdata1 = mem_rdata;
          end else begin
            done0  = 1'b1;
            rdata0 = mem_rdata;
          end
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    w_sel_addr  = w_grant_id ? addr1  : addr0;
    w_sel_wdata = w_grant_id ? wdata1 : wdata0;
    w_sel_we    = w_grant_id ? we1    : we0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_prio  <= 1'b0;
      r_id    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_we    <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_grant) begin
        r_id    <= w_grant_id;
        r_prio  <= ~w_grant_id;
        r_addr  <= w_sel_addr;
        r_wdata <= w_sel_wdata;
        r_we    <= w_sel_we;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed vector table, hand-written
// corner sequences, then randomized traffic against a schedule-based model.
module tb_mem_arbiter;
  localparam int AW    = 24;
  localparam int DW    = 16;
  localparam int NRAND = 1500;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0, req1, we0, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          done0, done1, mem_we, busy;
  logic [DW-1:0] rdata0, rdata1, mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic [AW-1:0] mem_addr;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1),
    .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1),
    .we0(we0), .we1(we1),
    .done0(done0), .done1(done1),
    .rdata0(rdata0), .rdata1(rdata1),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  // Memory stand-in: registered read of an address-derived pattern.
  function automatic logic [DW-1:0] rd_fn(input logic [AW-1:0] a);
    return a[15:0] ^ {8'h00, a[23:16]} ^ 16'hFEE6;
  endfunction

  always @(posedge clk) mem_rdata <= rd_fn(mem_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drop_inputs();
    req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_done0"},  32'(done0),     32'd0);
    chk({tag, "_done1"},  32'(done1),     32'd0);
    chk({tag, "_busy"},   32'(busy),      32'd0);
    chk({tag, "_mem_we"}, 32'(mem_we),    32'd0);
    chk({tag, "_maddr"},  32'(mem_addr),  32'd0);
    chk({tag, "_mwdata"}, 32'(mem_wdata), 32'd0);
    chk({tag, "_rdata0"}, 32'(rdata0),    32'd0);
    chk({tag, "_rdata1"}, 32'(rdata1),    32'd0);
  endtask

  typedef struct {
    logic          r0, r1;
    logic [AW-1:0] a0, a1;
    logic [DW-1:0] d0, d1;
    logic          w0, w1;
    logic          exp_id;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_wdata;
    logic          exp_we;
    logic [DW-1:0] exp_rdata;
  } vec_t;

  vec_t vecs[7];

  typedef struct packed {
    logic          id;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          we;
  } txn_t;

  txn_t iss_q[NRAND+4];
  bit   iss_v[NRAND+4];
  txn_t rsp_q[NRAND+4];
  bit   rsp_v[NRAND+4];

  task automatic run_row(input int k);
    vec_t v;
    v = vecs[k];
    req0 = v.r0; req1 = v.r1; addr0 = v.a0; addr1 = v.a1;
    wdata0 = v.d0; wdata1 = v.d1; we0 = v.w0; we1 = v.w1;
    @(negedge clk);
    chk("row_idle_busy", 32'(busy), 32'd0);
    tick();
    // Scramble inputs mid-flight; the latched request must be unaffected.
    req0 = 1'b0; req1 = 1'b0; addr0 = ~v.a0; addr1 = ~v.a1;
    wdata0 = ~v.d0; wdata1 = ~v.d1; we0 = ~v.w0; we1 = ~v.w1;
    @(negedge clk);
    chk("row_mem_addr",  32'(mem_addr),  32'(v.exp_addr));
    chk("row_mem_wdata", 32'(mem_wdata), 32'(v.exp_wdata));
    chk("row_mem_we",    32'(mem_we),    32'(v.exp_we));
    chk("row_iss_busy",  32'(busy),      32'd1);
    chk("row_iss_done",  32'({done1, done0}), 32'd0);
    tick();
    @(negedge clk);
    chk("row_done0", 32'(done0), 32'(v.exp_id == 1'b0));
    chk("row_done1", 32'(done1), 32'(v.exp_id == 1'b1));
    chk("row_resp_we", 32'(mem_we), 32'd0);
    if (v.exp_id) begin
      chk("row_rdata0_idle", 32'(rdata0), 32'd0);
      if (!v.exp_we) chk("row_rdata1", 32'(rdata1), 32'(v.exp_rdata));
    end else begin
      chk("row_rdata1_idle", 32'(rdata1), 32'd0);
      if (!v.exp_we) chk("row_rdata0", 32'(rdata0), 32'(v.exp_rdata));
    end
    $display("row %0d: id=%0d addr=0x%06h we=%0d done={%0d,%0d}",
             k, v.exp_id, v.exp_addr, v.exp_we, done1, done0);
    tick();
    drop_inputs();
  endtask

  logic          m_win;
  logic          m_prio;
  int            next_free;
  int            n_grants;
  txn_t          t;
  logic [DW-1:0] e_rd0, e_rd1;
  logic          e_d0, e_d1, e_busy;
  txn_t          e_iss;

  initial begin
    //            r0    r1    a0           a1           d0        d1        w0    w1    id    addr         wdata     we    rdata
    vecs[0] = '{1'b1, 1'b0, 24'h004009, 24'h123456, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 24'h004009, 16'h0000, 1'b0, 16'hBEEF};
    vecs[1] = '{1'b0, 1'b1, 24'h000000, 24'h000100, 16'h0000, 16'h1234, 1'b0, 1'b1, 1'b1, 24'h000100, 16'h1234, 1'b1, 16'h0000};
    vecs[2] = '{1'b1, 1'b1, 24'hFFFFFF, 24'h000001, 16'hFFFF, 16'h0001, 1'b1, 1'b0, 1'b0, 24'hFFFFFF, 16'hFFFF, 1'b1, 16'h0000};
    vecs[3] = '{1'b1, 1'b1, 24'h111111, 24'hABCDEF, 16'hAAAA, 16'h5555, 1'b1, 1'b0, 1'b1, 24'hABCDEF, 16'h5555, 1'b0, 16'h33A2};
    vecs[4] = '{1'b0, 1'b1, 24'h000000, 24'h800001, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 24'h800001, 16'h0000, 1'b0, 16'hFE67};
    vecs[5] = '{1'b1, 1'b1, 24'h000000, 24'hC0FFEE, 16'h0000, 16'hBEEF, 1'b0, 1'b1, 1'b0, 24'h000000, 16'h0000, 1'b0, 16'hFEE6};
    vecs[6] = '{1'b1, 1'b1, 24'h000002, 24'h7E5A3C, 16'h0000, 16'hC3A5, 1'b0, 1'b0, 1'b1, 24'h7E5A3C, 16'hC3A5, 1'b0, 16'hA4A4};

    // Reset with requests pending: everything must stay quiet.
    drop_inputs();
    rst = 1'b1; req0 = 1'b1; req1 = 1'b1; we0 = 1'b1; addr0 = 24'hFFFFFF;
    tick();
    tick();
    @(negedge clk);
    chk_quiet("reset");
    tick();
    rst = 1'b0;
    drop_inputs();
    @(negedge clk);
    chk("post_reset_busy", 32'(busy), 32'd0);
    tick();

    for (int k = 0; k < 7; k++) run_row(k);

    // Continuous tie after reset: grants alternate 0,1,0,1.
    rst = 1'b1;
    @(negedge clk);
    tick();
    rst = 1'b0;
    for (int k = 0; k < 12; k++) begin
      req0 = 1'b1; req1 = 1'b1;
      addr0 = 24'h00A000 + 24'(k); addr1 = 24'h00B000 + 24'(k);
      @(negedge clk);
      chk("tie_done0", 32'(done0), 32'((k % 3 == 2) && ((k / 3) % 2 == 0)));
      chk("tie_done1", 32'(done1), 32'((k % 3 == 2) && ((k / 3) % 2 == 1)));
      chk("tie_excl",  32'(done0 & done1), 32'd0);
      if (done0 || done1) $display("tie: cycle %0d grant to requester %0d", k, done1);
      tick();
    end
    drop_inputs();

    // Address change while the access is in ISSUE.
    req0 = 1'b1; addr0 = 24'h000010;
    @(negedge clk);
    tick();
    req0 = 1'b0; addr0 = 24'h000020;
    @(negedge clk);
    chk("midflight_addr", 32'(mem_addr), 32'h10);
    tick();
    @(negedge clk);
    chk("midflight_done0", 32'(done0), 32'd1);
    chk("midflight_rdata0", 32'(rdata0), 32'(rd_fn(24'h000010)));
    $display("midflight: addr=0x%06h done0=%0d", 24'h000010, done0);
    tick();

    // Reset during ISSUE of a write from requester 1 (prio currently 1).
    req1 = 1'b1; we1 = 1'b1; addr1 = 24'h000055; wdata1 = 16'h9999;
    @(negedge clk);
    tick();
    rst = 1'b1; req1 = 1'b0; we1 = 1'b0;
    @(negedge clk);
    chk("rstiss_mem_we_during", 32'(mem_we), 32'd0);
    chk("rstiss_busy_during", 32'(busy), 32'd0);
    tick();
    rst = 1'b0;
    req0 = 1'b1; req1 = 1'b1; addr0 = 24'h000AAA; addr1 = 24'h000BBB; we0 = 1'b0; we1 = 1'b1;
    @(negedge clk);
    chk("rstiss_mem_we_after", 32'(mem_we), 32'd0);
    chk("rstiss_busy_after", 32'(busy), 32'd0);
    chk("rstiss_no_done1", 32'(done1), 32'd0);
    tick();
    drop_inputs();
    @(negedge clk);
    chk("rstiss_tie_addr", 32'(mem_addr), 32'h000AAA);
    chk("rstiss_tie_we", 32'(mem_we), 32'd0);
    chk("rstiss_no_done1_b", 32'(done1), 32'd0);
    tick();
    @(negedge clk);
    chk("rstiss_tie_done0", 32'(done0), 32'd1);
    chk("rstiss_tie_done1", 32'(done1), 32'd0);
    $display("reset-in-issue: post-reset tie granted to requester %0d", done1);
    tick();

    // Randomized traffic against a cycle-schedule model: a grant at cycle c
    // occupies the memory in c+1, completes in c+2, and frees the arbiter at c+3.
    next_free = 0;
    m_prio    = 1'b0;
    n_grants  = 0;
    for (int c = 0; c < NRAND; c++) begin
      rst    = (c == 0) || ($urandom_range(63) == 0);
      req0   = ($urandom_range(2) != 0);
      req1   = ($urandom_range(2) != 0);
      addr0  = AW'($urandom);
      addr1  = AW'($urandom);
      wdata0 = DW'($urandom);
      wdata1 = DW'($urandom);
      we0    = 1'($urandom);
      we1    = 1'($urandom);
      @(negedge clk);

      e_iss  = iss_v[c] ? iss_q[c] : '0;
      e_busy = iss_v[c] || rsp_v[c];
      e_d0   = rsp_v[c] && !rsp_q[c].id;
      e_d1   = rsp_v[c] && rsp_q[c].id;
      e_rd0  = (e_d0 && !rsp_q[c].we) ? rd_fn(rsp_q[c].addr) : '0;
      e_rd1  = (e_d1 && !rsp_q[c].we) ? rd_fn(rsp_q[c].addr) : '0;
      if (rst) begin
        e_iss = '0; e_busy = 1'b0; e_d0 = 1'b0; e_d1 = 1'b0; e_rd0 = '0; e_rd1 = '0;
      end
      chk("rand_busy",   32'(busy),      32'(e_busy));
      chk("rand_maddr",  32'(mem_addr),  32'(e_iss.addr));
      chk("rand_mwdata", 32'(mem_wdata), 32'(e_iss.wdata));
      chk("rand_mwe",    32'(mem_we),    32'(e_iss.we));
      chk("rand_done0",  32'(done0),     32'(e_d0));
      chk("rand_done1",  32'(done1),     32'(e_d1));
      if (!(e_d0 && rsp_q[c].we)) chk("rand_rdata0", 32'(rdata0), 32'(e_rd0));
      if (!(e_d1 && rsp_q[c].we)) chk("rand_rdata1", 32'(rdata1), 32'(e_rd1));

      if (rst) begin
        iss_v[c+1] = 1'b0; iss_v[c+2] = 1'b0;
        rsp_v[c+1] = 1'b0; rsp_v[c+2] = 1'b0;
        next_free  = c + 1;
        m_prio     = 1'b0;
      end else if (c >= next_free && (req0 || req1)) begin
        m_win   = (req0 && req1) ? m_prio : !req0;
        t.id    = m_win;
        t.addr  = m_win ? addr1  : addr0;
        t.wdata = m_win ? wdata1 : wdata0;
        t.we    = m_win ? we1    : we0;
        iss_q[c+1] = t; iss_v[c+1] = 1'b1;
        rsp_q[c+2] = t; rsp_v[c+2] = 1'b1;
        next_free  = c + 3;
        m_prio     = !m_win;
        n_grants++;
      end
      tick();
    end
    rst = 1'b0;
    drop_inputs();
    $display("random: %0d cycles, %0d grants", NRAND, n_grants);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
